// File: rtl/exec_sequencer.sv
// Execute-stage sequencer in front of the 8-bit ALU: owns accumulators A/B,
// fetches memory operands over req/ack, issues ALU ops and writes back or stores.
module exec_sequencer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [7:0]  dmem_addr,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [7:0]  dmem_wdata,
   input  logic [7:0]  dmem_rdata,
   input  logic        dmem_ack,
   output logic [5:0]  alu_opcode,
   output logic [7:0]  alu_in1,
   output logic [7:0]  alu_in2,
   input  logic [7:0]  alu_out,
   output logic [7:0]  reg_a,
   output logic [7:0]  reg_b,
   output logic        zero,
   output logic        err
);

   localparam logic [5:0] NOP   = 6'h00, LDA   = 6'h01, LDB   = 6'h02, LDCA  = 6'h03,
                          LDCB  = 6'h04, STA   = 6'h05, STB   = 6'h06,
                          ADDA  = 6'h08, ADDB  = 6'h09, SUBA  = 6'h0A, SUBB  = 6'h0B,
                          ANDA  = 6'h0C, ANDB  = 6'h0D, ORA   = 6'h0E, ORB   = 6'h0F,
                          ADDCA = 6'h10, ADDCB = 6'h11, SUBCA = 6'h12, SUBCB = 6'h13,
                          ANDCA = 6'h14, ANDCB = 6'h15, ORCA  = 6'h16, ORCB  = 6'h17,
                          ASLA  = 6'h18, ASRA  = 6'h19;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_MEM_RD, S_EXEC, S_WB, S_MEM_WR} state_t;

   state_t     state;
   logic [5:0] op;
   logic [7:0] opnd;
   logic [7:0] cnt;
   logic [5:0] new_op;
   logic [7:0] new_opnd;
   logic       unused_bits;

   assign new_op      = instr[15:10];
   assign new_opnd    = instr[7:0];
   assign unused_bits = ^instr[9:8];
   assign instr_ready = (state == S_IDLE);

   function automatic logic is_mem_alu(input logic [5:0] o);
      return o inside {ADDA, ADDB, SUBA, SUBB, ANDA, ANDB, ORA, ORB};
   endfunction

   function automatic logic is_const_alu(input logic [5:0] o);
      return o inside {ADDCA, ADDCB, SUBCA, SUBCB, ANDCA, ANDCB, ORCA, ORCB, ASLA, ASRA};
   endfunction

   function automatic logic is_b_op(input logic [5:0] o);
      return o inside {ADDB, SUBB, ANDB, ORB, ADDCB, SUBCB, ANDCB, ORCB};
   endfunction

   // Returns {in1, in2}: B-side ops put the operand on in1 so the ALU sees B on in2.
   function automatic logic [15:0] route(input logic [5:0] o, input logic [7:0] v,
                                         input logic [7:0] a, input logic [7:0] b);
      if (o == STB)
         return {8'h00, b};
      if (o == STA || o == ASLA || o == ASRA)
         return {a, 8'h00};
      if (is_b_op(o))
         return {v, b};
      return {a, v};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op         <= NOP;
         opnd       <= 8'h00;
         cnt        <= 8'h00;
         reg_a      <= 8'h00;
         reg_b      <= 8'h00;
         dmem_addr  <= 8'h00;
         dmem_wdata <= 8'h00;
         dmem_rd    <= 1'b0;
         dmem_wr    <= 1'b0;
         alu_opcode <= NOP;
         alu_in1    <= 8'h00;
         alu_in2    <= 8'h00;
         zero       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op   <= new_op;
                  opnd <= new_opnd;
                  if (new_op == LDCA) begin
                     reg_a <= new_opnd;
                     zero  <= (new_opnd == 8'h00);
                  end else if (new_op == LDCB) begin
                     reg_b <= new_opnd;
                     zero  <= (new_opnd == 8'h00);
                  end else if (new_op == LDA || new_op == LDB || is_mem_alu(new_op)) begin
                     state     <= S_MEM_RD;
                     dmem_addr <= new_opnd;
                     dmem_rd   <= 1'b1;
                     cnt       <= 8'h00;
                  end else if (is_const_alu(new_op) || new_op == STA || new_op == STB) begin
                     state                <= S_EXEC;
                     alu_opcode           <= new_op;
                     {alu_in1, alu_in2}   <= route(new_op, new_opnd, reg_a, reg_b);
                  end
               end
            end
            S_MEM_RD: begin
               if (dmem_ack) begin
                  dmem_rd <= 1'b0;
                  if (op == LDA) begin
                     reg_a <= dmem_rdata;
                     zero  <= (dmem_rdata == 8'h00);
                     state <= S_IDLE;
                  end else if (op == LDB) begin
                     reg_b <= dmem_rdata;
                     zero  <= (dmem_rdata == 8'h00);
                     state <= S_IDLE;
                  end else begin
                     state              <= S_EXEC;
                     alu_opcode         <= op;
                     {alu_in1, alu_in2} <= route(op, dmem_rdata, reg_a, reg_b);
                  end
               end else if (cnt == TO_LAST) begin
                  dmem_rd <= 1'b0;
                  err     <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'h01;
               end
            end
            S_EXEC: begin
               alu_opcode <= NOP;
               state      <= S_WB;
            end
            // The registered ALU result is valid in this state.
            S_WB: begin
               if (op == STA || op == STB) begin
                  dmem_wdata <= alu_out;
                  dmem_addr  <= opnd;
                  dmem_wr    <= 1'b1;
                  cnt        <= 8'h00;
                  state      <= S_MEM_WR;
               end else begin
                  if (is_b_op(op))
                     reg_b <= alu_out;
                  else
                     reg_a <= alu_out;
                  zero  <= (alu_out == 8'h00);
                  state <= S_IDLE;
               end
            end
            S_MEM_WR: begin
               if (dmem_ack) begin
                  dmem_wr <= 1'b0;
                  state   <= S_IDLE;
               end else if (cnt == TO_LAST) begin
                  dmem_wr <= 1'b0;
                  err     <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'h01;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer with a memory responder, an ALU model and
// an instruction-level reference model of the architectural state.
module tb_exec_sequencer;

   localparam int TO = 16;
   localparam logic [5:0] NOP   = 6'h00, LDA   = 6'h01, LDB   = 6'h02, LDCA  = 6'h03,
                          LDCB  = 6'h04, STA   = 6'h05, STB   = 6'h06,
                          ADDA  = 6'h08, ADDB  = 6'h09, SUBA  = 6'h0A, SUBB  = 6'h0B,
                          ANDA  = 6'h0C, ANDB  = 6'h0D, ORA   = 6'h0E, ORB   = 6'h0F,
                          ADDCA = 6'h10, ADDCB = 6'h11, SUBCA = 6'h12, SUBCB = 6'h13,
                          ANDCA = 6'h14, ANDCB = 6'h15, ORCA  = 6'h16, ORCB  = 6'h17,
                          ASLA  = 6'h18, ASRA  = 6'h19;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       instr_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic       instr_ready;
   logic [7:0] dmem_addr, dmem_wdata, alu_in1, alu_in2, reg_a, reg_b;
   logic [7:0] dmem_rdata = 8'h00;
   logic       dmem_ack = 1'b0;
   logic       dmem_rd, dmem_wr, zero, err;
   logic [5:0] alu_opcode;
   logic [7:0] alu_out = 8'h00;

   exec_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .dmem_addr(dmem_addr), .dmem_rd(dmem_rd),
      .dmem_wr(dmem_wr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .alu_opcode(alu_opcode), .alu_in1(alu_in1),
      .alu_in2(alu_in2), .alu_out(alu_out), .reg_a(reg_a), .reg_b(reg_b),
      .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int ack_dly = 0;
   int wcnt = 0;
   logic [7:0] ma = 8'h00, mb = 8'h00;
   logic mz = 1'b0, merr = 1'b0;
   int lat, nexec;
   logic [7:0] ein1, ein2, swaddr, swdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] alu_f(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         ADDA, ADDB, ADDCA, ADDCB: return x + y;
         SUBA, SUBCA:              return x - y;
         SUBB, SUBCB:              return y - x;
         ANDA, ANDB, ANDCA, ANDCB: return x & y;
         ORA, ORB, ORCA, ORCB:     return x | y;
         ASLA:                     return {x[6:0], 1'b0};
         ASRA:                     return {x[7], x[7:1]};
         STA:                      return x;
         STB:                      return y;
         default:                  return 8'h00;
      endcase
   endfunction

   always @(posedge clk) alu_out <= alu_f(alu_opcode, alu_in1, alu_in2);

   // Memory responder: acks ack_dly cycles after a request first appears.
   always @(negedge clk) begin
      dmem_ack = 1'b0;
      if (dmem_rd || dmem_wr) begin
         if (wcnt == ack_dly) begin
            dmem_ack   = 1'b1;
            dmem_rdata = mem[dmem_addr];
            if (dmem_wr) mem[dmem_addr] = dmem_wdata;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic apply(input logic [5:0] o, input logic [7:0] x);
      case (o)
         ADDA, ADDCA: ma = ma + x;
         SUBA, SUBCA: ma = ma - x;
         ANDA, ANDCA: ma = ma & x;
         ORA, ORCA:   ma = ma | x;
         ADDB, ADDCB: mb = mb + x;
         SUBB, SUBCB: mb = mb - x;
         ANDB, ANDCB: mb = mb & x;
         ORB, ORCB:   mb = mb | x;
         ASLA:        ma = ma * 2;
         ASRA:        ma = (ma / 2) | (ma & 8'h80);
         default: ;
      endcase
      if (o inside {ADDB, SUBB, ANDB, ORB, ADDCB, SUBCB, ANDCB, ORCB}) mz = (mb == 0);
      else mz = (ma == 0);
   endtask

   task automatic model(input logic [5:0] o, input logic [7:0] v, input int d,
                        output int elat, output int eexec);
      bit to = (d >= TO);
      int w = to ? TO : d + 1;
      elat = 0;
      eexec = 0;
      case (o)
         LDCA: begin ma = v; mz = (v == 0); end
         LDCB: begin mb = v; mz = (v == 0); end
         LDA, LDB: begin
            elat = w;
            if (to) merr = 1'b1;
            else if (o == LDA) begin ma = ref_mem[v]; mz = (ma == 0); end
            else begin mb = ref_mem[v]; mz = (mb == 0); end
         end
         ADDA, ADDB, SUBA, SUBB, ANDA, ANDB, ORA, ORB: begin
            elat = w;
            if (to) merr = 1'b1;
            else begin elat = w + 2; eexec = 1; apply(o, ref_mem[v]); end
         end
         ADDCA, ADDCB, SUBCA, SUBCB, ANDCA, ANDCB, ORCA, ORCB, ASLA, ASRA: begin
            elat = 2; eexec = 1; apply(o, v);
         end
         STA, STB: begin
            elat = 2 + w; eexec = 1;
            if (to) merr = 1'b1;
            else ref_mem[v] = (o == STA) ? ma : mb;
         end
         default: ;
      endcase
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [7:0] v, input int d);
      ack_dly = d;
      @(negedge clk);
      instr_valid = 1'b1;
      instr = {o, 2'b11, v};
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'h0000;
      lat = 0;
      nexec = 0;
      while (!instr_ready && lat < 200) begin
         if (alu_opcode != NOP) begin nexec++; ein1 = alu_in1; ein2 = alu_in2; end
         if (dmem_wr) begin swaddr = dmem_addr; swdata = dmem_wdata; end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_and_check(input logic [5:0] o, input logic [7:0] v, input int d);
      int elat, eexec;
      model(o, v, d, elat, eexec);
      run_instr(o, v, d);
      chk("latency", lat, elat);
      chk("exec_cycles", nexec, eexec);
      chk("reg_a", reg_a, ma);
      chk("reg_b", reg_b, mb);
      chk("zero", zero, mz);
      chk("err", err, merr);
      chk("idle_req", {dmem_rd, dmem_wr, alu_opcode}, {2'b00, NOP});
      if ((o == STA || o == STB) && d < TO) begin
         chk("store_mem", mem[v], ref_mem[v]);
         chk("store_addr", swaddr, v);
         chk("store_data", swdata, ref_mem[v]);
      end
   endtask

   logic [5:0] ops [30] = '{NOP, LDA, LDB, LDCA, LDCB, STA, STB, ADDA, ADDB, SUBA, SUBB,
                            ANDA, ANDB, ORA, ORB, ADDCA, ADDCB, SUBCA, SUBCB, ANDCA,
                            ANDCB, ORCA, ORCB, ASLA, ASRA, 6'h07, 6'h20, 6'h2A, 6'h3F, LDCA};

   initial begin
      int n, r, d;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_outs", {reg_a, reg_b, dmem_addr, dmem_wdata, alu_in1, alu_in2}, 48'h0);
      chk("rst_ctl", {instr_ready, dmem_rd, dmem_wr, zero, err, alu_opcode}, {5'b10000, NOP});

      run_and_check(LDCA, 8'h05, 0);
      run_and_check(LDCB, 8'h03, 0);
      run_and_check(ADDCA, 8'h03, 0);
      chk("t1_a", reg_a, 8'h08);
      chk("t1_b", reg_b, 8'h03);
      chk("t1_busy", lat, 2);

      run_and_check(LDCA, 8'h05, 0);
      run_and_check(LDCB, 8'h10, 0);
      mem[8'h20] = 8'h04;
      ref_mem[8'h20] = 8'h04;
      run_and_check(SUBB, 8'h20, 2);
      chk("t2_in1", ein1, 8'h04);
      chk("t2_in2", ein2, 8'h10);
      chk("t2_b", reg_b, 8'h0C);

      run_and_check(LDCA, 8'h81, 0);
      run_and_check(ASLA, 8'h00, 0);
      chk("t3_asl", reg_a, 8'h02);
      run_and_check(ASRA, 8'h00, 0);
      chk("t3_asr", reg_a, 8'h01);
      run_and_check(SUBCA, 8'h01, 0);
      chk("t3_sub", {reg_a, 7'h0, zero}, 16'h0001);

      run_and_check(LDCA, 8'hAA, 0);
      run_and_check(STA, 8'h7F, 3);
      chk("t4_data", {swaddr, swdata, reg_a}, 24'h7FAAAA);

      run_and_check(LDA, 8'h10, 255);
      chk("t5_err", {err, instr_ready, reg_a}, {2'b11, 8'hAA});
      chk("t5_lat", lat, TO);

      run_and_check(LDB, 8'h33, TO - 1);

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 19);
         if (r < 15) d = r % 6;
         else if (r < 17) d = TO - 1;
         else d = TO;
         run_and_check(ops[$urandom_range(0, 29)], 8'($urandom), d);
      end

      ack_dly = 255;
      @(negedge clk);
      instr_valid = 1'b1;
      instr = {STB, 2'b00, 8'h33};
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      n = 0;
      while (!dmem_wr && n < 10) begin @(posedge clk); #1; n++; end
      chk("t6_wr_up", dmem_wr, 1'b1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("t6_rst_outs", {reg_a, reg_b, dmem_addr, dmem_wdata, alu_in1, alu_in2}, 48'h0);
      chk("t6_rst_ctl", {instr_ready, dmem_rd, dmem_wr, zero, err, alu_opcode}, {5'b10000, NOP});
      @(negedge clk);
      reset = 1'b0;
      ma = 8'h00; mb = 8'h00; mz = 1'b0; merr = 1'b0;
      run_and_check(LDCA, 8'h5A, 0);
      chk("t6_after", reg_a, 8'h5A);
      run_and_check(ADDCB, 8'h07, 0);
      chk("t6_after_b", reg_b, 8'h07);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
